// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial bus: initiator FSM states, rw encoding, default widths.
package serial_bus_pkg;

  localparam int unsigned BusAddrWidth = 16;
  localparam int unsigned BusDataWidth = 8;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StAddr,
    StWaitResp,
    StSplitWait,
    StResp
  } init_state_e;

endpackage

// File: rtl/split_initiator_timeout.sv
// Response watchdog for the split initiator: counts cycles spent waiting on the target.
module split_initiator_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (!run_i || clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the cycle whose closing edge completes TIMEOUT_CYCLES waiting cycles.
  assign expired_o = run_i && !clr_i && (cnt_q == CntLast);

endmodule

// File: rtl/split_initiator.sv
// Requesting end of the split-capable serial bus: one host request in, one response out.
// Optional response timeout is built when SPLIT_INITIATOR_TIMEOUT_EN is defined.
module split_initiator
  import serial_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = BusAddrWidth,
  parameter int unsigned DATA_WIDTH     = BusDataWidth,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_split,
  output logic                  bus_req,
  input  logic                  bus_grant,
  output logic [ADDR_WIDTH-1:0] init_addr_out,
  output logic                  init_addr_out_valid,
  output logic [DATA_WIDTH-1:0] init_data_out,
  output logic                  init_data_out_valid,
  output logic                  init_rw,
  input  logic                  target_ack,
  input  logic                  target_split_ack,
  input  logic [DATA_WIDTH-1:0] target_data_in,
  input  logic                  target_data_in_valid,
  input  logic                  target_ready
);

  init_state_e           state_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  split_q;
  logic                  err_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic                  bus_req_q;
  logic                  addr_v_q;
  logic                  data_v_q;
  logic                  rw_q;

  logic done_hit;
  logic split_go;
  logic timeout_hit;

  assign done_hit = target_ack && ((write_q == RW_WRITE) || target_data_in_valid);
  assign split_go = (state_q == StWaitResp) && (write_q == RW_READ) && target_split_ack &&
                    !done_hit;

`ifdef SPLIT_INITIATOR_TIMEOUT_EN
  logic waiting;
  assign waiting = (state_q == StWaitResp) || (state_q == StSplitWait);

  split_initiator_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_i    (waiting),
    .clr_i    (split_go),
    .expired_o(timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      write_q     <= RW_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      split_q     <= 1'b0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      bus_req_q   <= 1'b0;
      addr_v_q    <= 1'b0;
      data_v_q    <= 1'b0;
      rw_q        <= 1'b0;
    end else begin
      // Address-phase strobes are single-cycle pulses.
      addr_v_q <= 1'b0;
      data_v_q <= 1'b0;
      rw_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q     <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            rdata_q     <= '0;
            split_q     <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            bus_req_q   <= 1'b1;
            state_q     <= StArb;
          end
        end
        StArb: begin
          if (bus_grant && target_ready) begin
            addr_v_q <= 1'b1;
            data_v_q <= (write_q == RW_WRITE);
            rw_q     <= write_q;
            state_q  <= StAddr;
          end
        end
        StAddr: begin
          state_q <= bus_grant ? StWaitResp : StArb;
        end
        StWaitResp: begin
          if (done_hit) begin
            if (write_q == RW_READ) rdata_q <= target_data_in;
            bus_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else if (split_go) begin
            split_q   <= 1'b1;
            bus_req_q <= 1'b0;
            state_q   <= StSplitWait;
          end else if (timeout_hit) begin
            err_q       <= 1'b1;
            rdata_q     <= '0;
            bus_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end
        end
        StSplitWait: begin
          if (target_data_in_valid && target_ack) begin
            rdata_q     <= target_data_in;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else if (timeout_hit) begin
            err_q       <= 1'b1;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready           = req_ready_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_rdata           = rdata_q;
  assign rsp_err             = err_q;
  assign rsp_split           = split_q;
  assign bus_req             = bus_req_q;
  assign init_addr_out       = addr_q;
  assign init_data_out       = wdata_q;
  assign init_rw             = rw_q;
  // A grant lost during the address cycle suppresses the strobes.
  assign init_addr_out_valid = addr_v_q & bus_grant;
  assign init_data_out_valid = data_v_q & bus_grant;

endmodule
